// File: rtl/conv3x3_mac_engine_if.sv
`default_nettype none
// ============================================================================
//  Module      : conv3x3_mac_engine_if
//  Description : Bundles the control, activation stream, weight ROM port and
//                result stream of conv3x3_mac_engine.
//                  start         - begin one window (honoured only when idle)
//                  act_*         - signed activation byte stream, valid/ready
//                  weight_addr   - registered ROM byte address
//                  weight_data   - ROM byte, valid one cycle after the address
//                  result_*      - signed dot product + filter index, valid/ready
//                  busy / done   - window in progress / end-of-window pulse
//                master : environment side (drives start, acts, ROM data, ready)
//                slave  : engine side
//  Revision    : 1.0 - initial release
// ============================================================================
interface conv3x3_mac_engine_if #(
    parameter int ADDR_W = 8,
    parameter int ACC_W  = 24
);
    logic              start;
    logic [7:0]        act_data;
    logic              act_valid;
    logic              act_ready;
    logic [ADDR_W-1:0] weight_addr;
    logic [7:0]        weight_data;
    logic [ACC_W-1:0]  result_data;
    logic [2:0]        result_filter;
    logic              result_valid;
    logic              result_ready;
    logic              busy;
    logic              done;

    modport master (
        output start, act_data, act_valid, weight_data, result_ready,
        input  act_ready, weight_addr, result_data, result_filter,
               result_valid, busy, done
    );

    modport slave (
        input  start, act_data, act_valid, weight_data, result_ready,
        output act_ready, weight_addr, result_data, result_filter,
               result_valid, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/conv3x3_mac_engine.sv
`default_nettype none
// ============================================================================
//  Module      : conv3x3_mac_engine
//  Description : Buffers one 3x3x3 signed activation window, then computes
//                NUM_FILTERS dot products against weights read from an external
//                byte ROM (1-cycle read latency) and streams one result per
//                filter downstream with a valid/ready handshake.
//  Ports       : clk, reset (synchronous, active-high)
//                bus (conv3x3_mac_engine_if.slave) - start, activation stream,
//                weight ROM port, result stream, busy, done
//  Options     : `define CONV_LEAKY_RELU_EN to scale negative results by 1/8
//                (arithmetic shift right by 3); timing is unchanged.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv3x3_mac_engine #(
    parameter int TAPS        = 27,
    parameter int NUM_FILTERS = 8,
    parameter int ADDR_W      = 8,
    parameter int ACC_W       = 24
) (
    input  wire logic             clk,
    input  wire logic             reset,
    conv3x3_mac_engine_if.slave   bus
);
    localparam int TAP_W = $clog2(TAPS + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_COMPUTE = 3'd2,
        S_DRAIN   = 3'd3,
        S_OUTPUT  = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t                   state_q, state_d;
    logic [TAP_W-1:0]         tap_q, tap_d;
    logic [2:0]               filter_q, filter_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [ADDR_W-1:0]        addr_q, addr_d;
    logic [ACC_W-1:0]         rdata_q, rdata_d;
    logic [2:0]               rfilt_q, rfilt_d;
    logic                     rvalid_q, rvalid_d;
    logic [7:0]               window_q [0:TAPS-1];

    logic                     win_we;
    logic [TAP_W-1:0]         w_idx;
    logic signed [7:0]        w_act;
    logic signed [7:0]        w_wt;
    logic signed [15:0]       w_prod;
    logic signed [ACC_W-1:0]  w_sum;
    logic signed [ACC_W-1:0]  w_result;

    // The ROM byte arriving now belongs to the previous tap, so pair it with
    // window[tap-1]. In DRAIN tap has advanced to TAPS, selecting the last tap.
    assign w_idx  = (tap_q == '0) ? '0 : tap_q - TAP_W'(1);
    assign w_act  = window_q[w_idx];
    assign w_wt   = bus.weight_data;
    assign w_prod = w_wt * w_act;
    assign w_sum  = acc_q + {{(ACC_W-16){w_prod[15]}}, w_prod};

`ifdef CONV_LEAKY_RELU_EN
    assign w_result = w_sum[ACC_W-1] ? (w_sum >>> 3) : w_sum;
`else
    assign w_result = w_sum;
`endif

    always_comb begin
        state_d  = state_q;
        tap_d    = tap_q;
        filter_d = filter_q;
        acc_d    = acc_q;
        addr_d   = addr_q;
        rdata_d  = rdata_q;
        rfilt_d  = rfilt_q;
        rvalid_d = rvalid_q;
        win_we   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_LOAD;
                    tap_d   = '0;
                end
            end
            S_LOAD: begin
                if (bus.act_valid) begin
                    win_we = 1'b1;
                    if (tap_q == TAP_W'(TAPS - 1)) begin
                        tap_d    = '0;
                        filter_d = '0;
                        acc_d    = '0;
                        addr_d   = '0;
                        state_d  = S_COMPUTE;
                    end else begin
                        tap_d = tap_q + TAP_W'(1);
                    end
                end
            end
            S_COMPUTE: begin
                if (tap_q != '0) begin
                    acc_d = w_sum;
                end
                tap_d = tap_q + TAP_W'(1);
                // Address for the next tap is registered now so it is on the
                // ROM port during that tap's cycle.
                if (tap_q == TAP_W'(TAPS - 1)) begin
                    state_d = S_DRAIN;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            S_DRAIN: begin
                acc_d    = w_sum;
                rdata_d  = w_result;
                rfilt_d  = filter_q;
                rvalid_d = 1'b1;
                state_d  = S_OUTPUT;
            end
            S_OUTPUT: begin
                if (bus.result_ready) begin
                    rvalid_d = 1'b0;
                    acc_d    = '0;
                    tap_d    = '0;
                    filter_d = filter_q + 3'd1;
                    if (filter_q == 3'(NUM_FILTERS - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        // Filters are contiguous in the ROM: next base follows
                        // the last tap of the current filter.
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = S_COMPUTE;
                    end
                end
            end
            S_DONE: begin
                filter_d = '0;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            tap_q    <= '0;
            filter_q <= '0;
            acc_q    <= '0;
            addr_q   <= '0;
            rdata_q  <= '0;
            rfilt_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tap_q    <= tap_d;
            filter_q <= filter_d;
            acc_q    <= acc_d;
            addr_q   <= addr_d;
            rdata_q  <= rdata_d;
            rfilt_q  <= rfilt_d;
            rvalid_q <= rvalid_d;
        end
    end

    // Window storage needs no reset: a window is always fully rewritten in
    // LOAD before COMPUTE reads it.
    always_ff @(posedge clk) begin
        if (win_we && !reset) begin
            window_q[tap_q] <= bus.act_data;
        end
    end

    assign bus.act_ready     = (state_q == S_LOAD);
    assign bus.weight_addr   = addr_q;
    assign bus.result_data   = rdata_q;
    assign bus.result_filter = rfilt_q;
    assign bus.result_valid  = rvalid_q;
    assign bus.busy          = (state_q == S_LOAD)  || (state_q == S_COMPUTE) ||
                               (state_q == S_DRAIN) || (state_q == S_OUTPUT);
    assign bus.done          = (state_q == S_DONE);

endmodule
`default_nettype wire
